// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Width of the per-grant beat counter; at least one bit even for MaxBurst=1.
  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 1) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter int NumReq  = 4,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic [NumReq-1:0]  gnt_onehot,
  output logic [IdWidth-1:0] gnt_idx,
  output logic               any
);

  // Scan (ptr+1 .. ptr+NumReq) mod NumReq and keep the first hit.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = (int'(ptr) + i) % NumReq;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = IdWidth'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one requester at a time owns the FIFO write port
// for one packet (capped at MaxBurst beats); beats pass through combinationally.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NumReq    = 4,
  parameter  int DataWidth = 8,
  parameter  int MaxBurst  = 4,
  localparam int IdWidth   = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_last_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          wvalid_o,
  input  logic                          wready_i,
  output logic [DataWidth-1:0]          data_o,
  output logic [IdWidth-1:0]            id_o,
  output logic [NumReq-1:0]             grant_o,
  output logic                          busy_o
);

  localparam int CntWidth = cnt_width(MaxBurst);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [NumReq-1:0]    r_grant;
  logic [IdWidth-1:0]   r_gidx;
  logic [IdWidth-1:0]   r_rr_ptr;
  logic [CntWidth-1:0]  r_beat_cnt;

  logic [NumReq-1:0]    w_pick_onehot;
  logic [IdWidth-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic                 w_locked;
  logic                 w_hs;
  logic                 w_release;

  rr_pick #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_rr_pick (
    .req        (req_valid_i),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_pick_onehot),
    .gnt_idx    (w_pick_idx),
    .any        (w_pick_any)
  );

  assign w_locked  = (r_state == ARB_LOCKED);
  assign w_hs      = w_locked & req_valid_i[r_gidx] & wready_i;
  assign w_release = w_hs & (req_last_i[r_gidx] |
                             (r_beat_cnt == CntWidth'(MaxBurst - 1)));

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= ARB_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state: lock on any request, unlock on last beat or burst cap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:   if (w_pick_any) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (w_release)  w_state_nxt = ARB_IDLE;
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant, round-robin pointer and beat counter bookkeeping.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= IdWidth'(NumReq - 1);
      r_beat_cnt <= '0;
    end else if (!w_locked && w_pick_any) begin
      r_grant    <= w_pick_onehot;
      r_gidx     <= w_pick_idx;
      r_beat_cnt <= '0;
    end else if (w_release) begin
      r_rr_ptr   <= r_gidx;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else if (w_hs) begin
      r_beat_cnt <= r_beat_cnt + CntWidth'(1);
    end
  end

  // Pass-through muxes from the granted requester; everything zero when idle.
  always_comb begin
    req_ready_o = '0;
    wvalid_o    = 1'b0;
    data_o      = '0;
    id_o        = '0;
    if (w_locked) begin
      wvalid_o            = req_valid_i[r_gidx];
      req_ready_o[r_gidx] = wready_i;
      data_o              = req_data_i[r_gidx*DataWidth +: DataWidth];
      id_o                = r_gidx;
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = w_locked;

endmodule
